// File: rtl/key_word_streamer.sv
// key_word_streamer: round-robin arbiter and word sequencer for the sideload key.
// It captures a wide key into a shadow register and streams it to the granted
// requester as consecutive WORD_W-bit words over a valid/ready bus. The shadow
// copy is wiped after every completed or aborted transfer.
//
// Handshake: word_valid_o and word_o stay stable until a cycle in which
// word_valid_o && word_ready_i. That cycle is the transfer of the word at
// word_idx_o, and the next word appears in the following cycle.
module key_word_streamer #(
    parameter int KEY_W   = 512,
    parameter int WORD_W  = 32,
    parameter int NUM_REQ = 2,
    localparam int NUM_WORDS = KEY_W / WORD_W,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               key_valid_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               clear_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               word_valid_o,
    output logic [WORD_W-1:0]  word_o,
    output logic [IDX_W-1:0]   word_idx_o,
    output logic               word_last_o,
    input  logic               word_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2,
        WIPE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [KEY_W-1:0] shadow_q;
    logic [IDX_W-1:0] idx_q;
    logic [PTR_W-1:0] rr_q;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             req_held;
    logic             handshake;
    logic             is_last;

    // Round-robin pick: first requester at or above the pointer, wrapping.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = PTR_W'((int'(rr_q) + off) % NUM_REQ);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Binary index of the current one-hot grant, and the pointer that follows it.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) gnt_idx = PTR_W'(i);
        end
        next_ptr = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end

    assign req_held  = |(req_i & gnt_o);
    assign handshake = word_valid_o && word_ready_i;
    assign is_last   = (idx_q == IDX_W'(NUM_WORDS - 1));

    // Word outputs are muxed straight from the registered shadow and index.
    assign word_o      = shadow_q[int'(idx_q) * WORD_W +: WORD_W];
    assign word_idx_o  = idx_q;
    assign word_last_o = is_last;

    // Transfer FSM with all control outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            rr_q         <= '0;
            gnt_o        <= '0;
            word_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid_i && pick_found && !clear_i) begin
                        state_q      <= STREAM;
                        shadow_q     <= key_i;
                        idx_q        <= '0;
                        gnt_o        <= NUM_REQ'(1) << pick_idx;
                        word_valid_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                STREAM: begin
                    // An abort wins over a simultaneous handshake.
                    if (clear_i || !req_held) begin
                        state_q      <= WIPE;
                        word_valid_o <= 1'b0;
                        gnt_o        <= '0;
                        shadow_q     <= '0;
                        idx_q        <= '0;
                        rr_q         <= next_ptr;
                    end else if (handshake) begin
                        idx_q <= idx_q + 1'b1;
                        if (is_last) begin
                            state_q      <= DONE;
                            word_valid_o <= 1'b0;
                            done_o       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q  <= WIPE;
                    done_o   <= 1'b0;
                    rr_q     <= next_ptr;
                    gnt_o    <= '0;
                    shadow_q <= '0;
                    idx_q    <= '0;
                end
                WIPE: begin
                    state_q  <= IDLE;
                    busy_o   <= 1'b0;
                    shadow_q <= '0;
                    idx_q    <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_word_streamer.sv
// Testbench for key_word_streamer: directed scenarios plus random transfers,
// scored against expected words pushed by the driver.
module tb_key_word_streamer;

    localparam int KEY_W     = 512;
    localparam int WORD_W    = 32;
    localparam int NUM_REQ   = 2;
    localparam int NUM_WORDS = KEY_W / WORD_W;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int EW        = NUM_REQ + IDX_W + 1 + WORD_W;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               key_valid_i = 1'b0;
    logic [KEY_W-1:0]   key_i = '0;
    logic [NUM_REQ-1:0] req_i = '0;
    logic               clear_i = 1'b0;
    logic [NUM_REQ-1:0] gnt_o;
    logic               word_valid_o;
    logic [WORD_W-1:0]  word_o;
    logic [IDX_W-1:0]   word_idx_o;
    logic               word_last_o;
    logic               word_ready_i = 1'b0;
    logic               busy_o;
    logic               done_o;

    key_word_streamer #(.KEY_W(KEY_W), .WORD_W(WORD_W), .NUM_REQ(NUM_REQ)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_valid_i  (key_valid_i),
        .key_i        (key_i),
        .req_i        (req_i),
        .clear_i      (clear_i),
        .gnt_o        (gnt_o),
        .word_valid_o (word_valid_o),
        .word_o       (word_o),
        .word_idx_o   (word_idx_o),
        .word_last_o  (word_last_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;
    int done_exp  = 0;
    int rr_m      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word is popped from the expected queue.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_o) done_seen++;
            if (word_valid_o && word_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word: unexpected word %0h idx %0d, expected none", word_o, word_idx_o);
                end else begin
                    chk("word", 64'({gnt_o, word_idx_o, word_last_o, word_o}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Reference arbitration: lowest requester at or above the pointer, wrapping.
    function automatic int model_pick(input logic [NUM_REQ-1:0] req);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[(rr_m + k) % NUM_REQ]) return (rr_m + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = '0;
        key_valid_i = 1'b0;
        clear_i = 1'b0;
        word_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", 64'({gnt_o, word_valid_o, word_o, word_idx_o, word_last_o, busy_o, done_o}), 64'd0);
        rst_ni = 1'b1;
        rr_m = 0;
    endtask

    // One transfer. stop_kind: 0 none, 1 clear, 2 change req, 3 reset; applied at handshake count stop_at.
    // ready_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
    task automatic run_transfer(input logic [KEY_W-1:0] key, input logic [NUM_REQ-1:0] req,
                                input int stop_kind, input int stop_at, input logic [NUM_REQ-1:0] req_after,
                                input int ready_mode, input int change_at, output int waited);
        int win;
        int hs;
        int budget;
        int n_exp;
        int p;
        logic v;
        logic [NUM_REQ-1:0] g;
        key_i = key;
        key_valid_i = 1'b1;
        req_i = req;
        win = model_pick(req);
        g = NUM_REQ'(1) << win;
        n_exp = (stop_kind == 0) ? NUM_WORDS : stop_at;
        for (int j = 0; j < n_exp; j++)
            exp_q.push_back({g, IDX_W'(j), (j == NUM_WORDS - 1), key[j*WORD_W +: WORD_W]});
        rr_m = (win + 1) % NUM_REQ;
        if (stop_kind == 0) done_exp++;
        waited = 0;
        while (!word_valid_o && waited < 20) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (!word_valid_o) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no word_valid after %0d cycles, expected grant %0h", waited, g);
            req_i = '0;
            return;
        end
        chk("grant", 64'(gnt_o), 64'(g));
        chk("busy", 64'(busy_o), 64'd1);
        hs = 0;
        budget = 0;
        while (hs < NUM_WORDS && budget < 400) begin
            if (stop_kind != 0 && hs == stop_at) break;
            budget++;
            if (change_at >= 0 && hs >= change_at) key_i = '0;
            p = (budget - 1) % 4;
            if (ready_mode == 0) word_ready_i = 1'b1;
            else if (ready_mode == 1) word_ready_i = (p == 0 || p == 3);
            else word_ready_i = 1'($urandom_range(0, 1));
            v = word_valid_o && word_ready_i;
            @(posedge clk_i);
            #1;
            if (v) hs++;
        end
        if (stop_kind == 0) begin
            chk("hs_count", 64'(hs), 64'(NUM_WORDS));
            chk("done_pulse", 64'(done_o), 64'd1);
            chk("done_valid", 64'(word_valid_o), 64'd0);
            chk("done_gnt", 64'(gnt_o), 64'(g));
            word_ready_i = 1'b0;
            req_i = req_after;
            @(posedge clk_i);
            #1;
            chk("wipe_gnt", 64'(gnt_o), 64'd0);
            chk("wipe_busy_done", 64'({busy_o, done_o}), 64'b10);
        end else begin
            chk("abort_idx", 64'(word_idx_o), 64'(stop_at));
            word_ready_i = 1'b0;
            if (stop_kind == 3) begin
                rst_ni = 1'b0;
                #1;
                chk("async_reset", 64'({gnt_o, word_valid_o, word_o, word_idx_o, word_last_o, busy_o, done_o}), 64'd0);
                chk("reset_shadow", 64'(dut.shadow_q == '0), 64'd1);
                req_i = '0;
                key_valid_i = 1'b0;
                @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                rr_m = 0;
            end else begin
                if (stop_kind == 1) clear_i = 1'b1;
                else req_i = req_after;
                @(posedge clk_i);
                #1;
                clear_i = 1'b0;
                req_i = req_after;
                chk("abort_state", 64'({word_valid_o, done_o, gnt_o, busy_o}), 64'({1'b0, 1'b0, NUM_REQ'(0), 1'b1}));
                if (stop_kind == 1) begin
                    @(posedge clk_i);
                    #1;
                    chk("abort_idle_busy", 64'({busy_o, done_o}), 64'd0);
                    chk("abort_shadow", 64'(dut.shadow_q == '0), 64'd1);
                end
            end
        end
    endtask

    // Main stimulus
    initial begin
        logic [KEY_W-1:0] pat_key;
        logic [KEY_W-1:0] rnd_key;
        int w;

        for (int j = 0; j < NUM_WORDS; j++)
            pat_key[j*WORD_W +: WORD_W] = {8'hA5, 8'(j), 16'hC3C3};
        chk("pattern_word0", 64'(pat_key[31:0]), 64'h00000000A500C3C3);

        do_reset();
        @(posedge clk_i);
        #1;

        // Basic transfer, ready always high
        run_transfer(pat_key, 2'b01, 0, 0, 2'b00, 0, -1, w);
        chk("first_latency", 64'(w), 64'd1);

        // Stalling consumer
        run_transfer(pat_key, 2'b01, 0, 0, 2'b00, 1, -1, w);

        // Both requesters held from reset: 01, 10, 01 with a two-cycle grant gap
        do_reset();
        run_transfer(pat_key, 2'b11, 0, 0, 2'b11, 0, -1, w);
        chk("rr_first_latency", 64'(w), 64'd1);
        run_transfer(pat_key, 2'b11, 0, 0, 2'b11, 0, -1, w);
        chk("rr_gap", 64'(w), 64'd2);
        run_transfer(pat_key, 2'b11, 0, 0, 2'b00, 0, -1, w);
        chk("rr_gap2", 64'(w), 64'd2);

        // Clear at idx 5
        run_transfer(pat_key, 2'b01, 1, 5, 2'b00, 0, -1, w);

        // Granted requester drops at idx 9 while requester 1 is asking
        run_transfer(pat_key, 2'b01, 2, 9, 2'b10, 0, -1, w);
        run_transfer(pat_key, 2'b10, 0, 0, 2'b00, 0, -1, w);
        chk("drop_regrant_gap", 64'(w), 64'd2);

        // Key input changes mid-stream; shadow copy is streamed
        run_transfer({KEY_W{1'b1}}, 2'b01, 0, 0, 2'b00, 2, 3, w);

        // Clear held in IDLE blocks any grant
        clear_i = 1'b1;
        key_valid_i = 1'b1;
        req_i = 2'b11;
        repeat (4) @(posedge clk_i);
        #1;
        chk("clear_idle", 64'({gnt_o, word_valid_o, busy_o}), 64'd0);
        clear_i = 1'b0;
        req_i = '0;
        @(posedge clk_i);
        #1;

        // Random transfers, some aborted by clear
        for (int t = 0; t < 8; t++) begin
            int kind;
            logic [NUM_REQ-1:0] rq;
            for (int j = 0; j < NUM_WORDS; j++) rnd_key[j*WORD_W +: WORD_W] = $urandom;
            rq = NUM_REQ'($urandom_range(1, 3));
            kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_transfer(rnd_key, rq, kind, $urandom_range(1, 15), 2'b00, 2, -1, w);
        end

        // Reset mid-transfer at idx 7
        run_transfer(pat_key, 2'b01, 3, 7, 2'b00, 0, -1, w);
        repeat (2) @(posedge clk_i);
        #1;
        run_transfer(pat_key, 2'b10, 0, 0, 2'b00, 2, -1, w);
        repeat (3) @(posedge clk_i);
        #1;

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(done_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
